// File: rtl/cosim_link_arbiter.sv
// cosim_link_arbiter: shares one co-simulation export/import link among
// N_CH requesters. Each transaction exports one word tagged with its channel
// id, waits for the matching imported reply, then routes the reply back to
// the requesting channel. Only one transaction is in flight at a time, and
// channels are served round-robin.
//
// Optional build macro COSIM_ARB_TIMEOUT_EN adds a watchdog on the wait for
// the reply. The watchdog aborts the transaction with timeout_err_o and a
// zero reply after TIMEOUT cycles. Without the macro the arbiter waits for
// the reply indefinitely and timeout_err_o is tied low.
module cosim_link_arbiter #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_CH-1:0]        req_i,
    input  logic [N_CH*DATA_W-1:0] req_data_i,
    output logic [N_CH-1:0]        gnt_o,
    output logic [N_CH-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_data_o,
    output logic                   exp_valid_o,
    input  logic                   exp_ready_i,
    output logic [DATA_W-1:0]      exp_data_o,
    output logic [ID_W-1:0]        exp_id_o,
    input  logic                   imp_valid_i,
    input  logic [DATA_W-1:0]      imp_data_i,
    input  logic [ID_W-1:0]        imp_id_i,
    output logic                   busy_o,
    output logic                   id_err_o,
    output logic                   timeout_err_o
);

    localparam int PTR_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        IDLE,
        EXPORT,
        WAIT_IMP,
        RESPOND
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    cur_q, cur_d;
    logic [DATA_W-1:0]   exp_data_q, exp_data_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [N_CH-1:0]     gnt_q, gnt_d;
    logic                id_err_q, id_err_d;
    logic                tmo_q, tmo_d;

    logic [DATA_W-1:0]   ch_data [N_CH];
    logic [PTR_W-1:0]    cand;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_hit;

`ifdef COSIM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
    // TIMEOUT only matters when the watchdog is built in
    logic                unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_split
        assign ch_data[g] = req_data_i[g*DATA_W +: DATA_W];
    end

    // Round-robin pick: first requesting channel at or after the pointer, wrapping
    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = PTR_W'((int'(ptr_q) + i) % N_CH);
            if (req_i[cand]) begin
                pick_hit = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // State register and all registered outputs; reset aborts any transaction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cur_q      <= '0;
            exp_data_q <= '0;
            rsp_data_q <= '0;
            gnt_q      <= '0;
            id_err_q   <= 1'b0;
            tmo_q      <= 1'b0;
`ifdef COSIM_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            exp_data_q <= exp_data_d;
            rsp_data_q <= rsp_data_d;
            gnt_q      <= gnt_d;
            id_err_q   <= id_err_d;
            tmo_q      <= tmo_d;
`ifdef COSIM_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Transaction sequencing: grant, export handshake, reply wait, respond
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        exp_data_d = exp_data_q;
        rsp_data_d = rsp_data_q;
        gnt_d      = '0;
        id_err_d   = 1'b0;
        tmo_d      = 1'b0;
`ifdef COSIM_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    cur_d      = pick_idx;
                    exp_data_d = ch_data[pick_idx];
                    gnt_d      = N_CH'(1) << pick_idx;
                    state_d    = EXPORT;
                end
            end
            EXPORT: begin
                if (exp_ready_i) begin
                    state_d = WAIT_IMP;
`ifdef COSIM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT_IMP: begin
                if (imp_valid_i && (imp_id_i == ID_W'(cur_q))) begin
                    rsp_data_d = imp_data_i;
                    state_d    = RESPOND;
                end else begin
                    if (imp_valid_i) begin
                        id_err_d = 1'b1;
                    end
`ifdef COSIM_ARB_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data_d = '0;
                        tmo_d      = 1'b1;
                        state_d    = RESPOND;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            RESPOND: begin
                ptr_d   = (cur_q == PTR_W'(N_CH - 1)) ? '0 : cur_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_o         = gnt_q;
    assign exp_valid_o   = (state_q == EXPORT);
    assign exp_data_o    = exp_data_q;
    assign exp_id_o      = ID_W'(cur_q);
    assign rsp_valid_o   = (state_q == RESPOND) ? (N_CH'(1) << cur_q) : '0;
    assign rsp_data_o    = rsp_data_q;
    assign busy_o        = (state_q != IDLE);
    assign id_err_o      = id_err_q;
`ifdef COSIM_ARB_TIMEOUT_EN
    assign timeout_err_o = tmo_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cosim_link_arbiter.sv
// Testbench for cosim_link_arbiter. It runs directed scenarios followed by
// randomized transactions. A round-robin reference model, computed directly
// from the channel-selection rule, predicts each grant.
module tb_cosim_link_arbiter;

    localparam int N_CH    = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int TIMEOUT = 8;

    logic                   clk;
    logic                   rstN;
    logic [N_CH-1:0]        req;
    logic [N_CH*DATA_W-1:0] reqData;
    logic [N_CH-1:0]        gnt;
    logic [N_CH-1:0]        rspValid;
    logic [DATA_W-1:0]      rspData;
    logic                   expValid;
    logic                   expReady;
    logic [DATA_W-1:0]      expData;
    logic [ID_W-1:0]        expId;
    logic                   impValid;
    logic [DATA_W-1:0]      impData;
    logic [ID_W-1:0]        impId;
    logic                   busy;
    logic                   idErr;
    logic                   tmoErr;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] chData [N_CH];
    logic [N_CH-1:0]   pending;
    int                modelPtr;

    cosim_link_arbiter #(
        .N_CH    (N_CH),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .req_i         (req),
        .req_data_i    (reqData),
        .gnt_o         (gnt),
        .rsp_valid_o   (rspValid),
        .rsp_data_o    (rspData),
        .exp_valid_o   (expValid),
        .exp_ready_i   (expReady),
        .exp_data_o    (expData),
        .exp_id_o      (expId),
        .imp_valid_i   (impValid),
        .imp_data_i    (impData),
        .imp_id_i      (impId),
        .busy_o        (busy),
        .id_err_o      (idErr),
        .timeout_err_o (tmoErr)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Channel choice from the round-robin rule: first requester at or after ptr
    function automatic int modelPick(input logic [N_CH-1:0] mask, input int ptr);
        int m;
        m = int'(mask);
        for (int off = 0; off < N_CH; off++) begin
            if (((m >> ((ptr + off) % N_CH)) & 1) != 0) return (ptr + off) % N_CH;
        end
        return -1;
    endfunction

    function automatic logic [N_CH-1:0] oneHot(input int c);
        return N_CH'(1) << c;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] mask, input logic ready);
        req = mask;
        for (int c = 0; c < N_CH; c++) reqData[c*DATA_W +: DATA_W] = chData[c];
        expReady = ready;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, 64'(gnt), 0);
        checkOutput({tag, "_rsp_valid"}, 64'(rspValid), 0);
        checkOutput({tag, "_rsp_data"}, 64'(rspData), 0);
        checkOutput({tag, "_exp_valid"}, 64'(expValid), 0);
        checkOutput({tag, "_exp_data"}, 64'(expData), 0);
        checkOutput({tag, "_exp_id"}, 64'(expId), 0);
        checkOutput({tag, "_busy"}, 64'(busy), 0);
        checkOutput({tag, "_id_err"}, 64'(idErr), 0);
        checkOutput({tag, "_timeout_err"}, 64'(tmoErr), 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the first WAIT_IMP negedge
    task automatic grantPhase(input int readyDelay, output int k);
        applyStimulus(pending, readyDelay == 0);
        k = modelPick(pending, modelPtr);
        @(negedge clk);
        checkOutput("gnt", 64'(gnt), 64'(oneHot(k)));
        checkOutput("exp_valid_on_grant", 64'(expValid), 1);
        checkOutput("exp_data", 64'(expData), 64'(chData[k]));
        checkOutput("exp_id", 64'(expId), 64'(k));
        checkOutput("rsp_valid_quiet", 64'(rspValid), 0);
        pending = pending & ~oneHot(k);
        req = pending;
        for (int i = 0; i < readyDelay; i++) begin
            @(negedge clk);
            checkOutput("exp_valid_held", 64'(expValid), 1);
            checkOutput("exp_data_stable", 64'(expData), 64'(chData[k]));
            checkOutput("exp_id_stable", 64'(expId), 64'(k));
            checkOutput("no_second_gnt", 64'(gnt), 0);
        end
        expReady = 1'b1;
        @(negedge clk);
        expReady = 1'b0;
        checkOutput("exp_valid_drop", 64'(expValid), 0);
        checkOutput("busy_wait", 64'(busy), 1);
    endtask

    // Optional mismatched replies, then the matching one, then back to idle
    task automatic replyPhase(input int k, input int nBad, input int badId, input logic [DATA_W-1:0] reply);
        for (int b = 0; b < nBad; b++) begin
            impValid = 1'b1;
            impId    = (badId >= 0) ? ID_W'(badId)
                                    : ID_W'((k + 1 + int'($urandom_range(0, (1 << ID_W) - 2))) % (1 << ID_W));
            impData  = $urandom;
            @(negedge clk);
            impValid = 1'b0;
            checkOutput("id_err_pulse", 64'(idErr), 1);
            checkOutput("busy_after_bad_id", 64'(busy), 1);
            checkOutput("no_rsp_on_bad_id", 64'(rspValid), 0);
        end
        impValid = 1'b1;
        impId    = ID_W'(k);
        impData  = reply;
        @(negedge clk);
        impValid = 1'b0;
        checkOutput("rsp_valid", 64'(rspValid), 64'(oneHot(k)));
        checkOutput("rsp_data", 64'(rspData), 64'(reply));
        checkOutput("id_err_clear", 64'(idErr), 0);
        checkOutput("timeout_err_quiet", 64'(tmoErr), 0);
        @(negedge clk);
        checkOutput("busy_idle", 64'(busy), 0);
        checkOutput("rsp_valid_pulse_end", 64'(rspValid), 0);
        checkOutput("rsp_data_hold", 64'(rspData), 64'(reply));
        modelPtr = (k + 1) % N_CH;
    endtask

    initial begin
        int k;
        logic [N_CH-1:0] newBits;
        logic [DATA_W-1:0] v;
        bit sawTmo;

        rstN     = 1'b0;
        req      = '0;
        reqData  = '0;
        expReady = 1'b0;
        impValid = 1'b0;
        impData  = '0;
        impId    = '0;
        pending  = '0;
        modelPtr = 0;
        for (int c = 0; c < N_CH; c++) chData[c] = '0;

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;
        @(negedge clk);

        // Single request on channel 1; minimum-latency path
        chData[1] = 32'hfafafafa;
        pending   = 4'b0010;
        grantPhase(0, k);
        replyPhase(k, 0, -1, 32'h0000_0001);

        // Backpressure: five stalled export cycles with another channel waiting
        chData[0] = 32'h1234_5678;
        chData[2] = 32'h0bad_cafe;
        pending   = 4'b0101;
        grantPhase(5, k);
        replyPhase(k, 0, -1, 32'h5555_aaaa);
        grantPhase(0, k);
        replyPhase(k, 0, -1, 32'h0000_0ac3);

        // Wrong id: channel 2 active, reply tagged 3 first
        chData[2] = 32'h2222_2222;
        pending   = 4'b0100;
        grantPhase(0, k);
        replyPhase(k, 1, 3, 32'hdead_beef);

        // Import traffic while idle is ignored
        impValid = 1'b1;
        impId    = ID_W'(1);
        impData  = 32'h7777_7777;
        @(negedge clk);
        impValid = 1'b0;
        checkOutput("idle_imp_no_id_err", 64'(idErr), 0);
        checkOutput("idle_imp_not_busy", 64'(busy), 0);
        checkOutput("idle_imp_no_rsp", 64'(rspValid), 0);

        // Reset during WAIT_IMP, then channel 3 from a cleared pointer
        chData[0] = 32'h0f0f_0f0f;
        pending   = 4'b0001;
        grantPhase(0, k);
        rstN = 1'b0;
        #1;
        checkAllZero("mid_reset");
        @(negedge clk);
        rstN     = 1'b1;
        modelPtr = 0;
        @(negedge clk);
        checkOutput("abort_no_rsp", 64'(rspValid), 0);
        checkOutput("abort_idle", 64'(busy), 0);
        chData[3] = 32'h3333_0003;
        pending   = 4'b1000;
        grantPhase(0, k);
        replyPhase(k, 0, -1, 32'h0000_0333);

        // Fairness with all requests held: order 0,1,2,3,0
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < N_CH; c++) chData[c] = $urandom | 32'h1;
            pending = 4'b1111;
            grantPhase(0, k);
            checkOutput("rr_order", 64'(gnt === 4'b0000 ? k : k), 64'(t % N_CH));
            replyPhase(k, 0, -1, $urandom | 32'h1);
        end
        pending = '0;
        req     = '0;

`ifdef COSIM_ARB_TIMEOUT_EN
        // No reply: abort after TIMEOUT cycles in WAIT_IMP with a zero reply
        chData[1] = 32'h1111_0001;
        pending   = 4'b0010;
        grantPhase(0, k);
        for (int i = 1; i < TIMEOUT; i++) begin
            @(negedge clk);
            checkOutput("tmo_not_yet", 64'(tmoErr), 0);
            checkOutput("tmo_no_rsp_yet", 64'(rspValid), 0);
            checkOutput("tmo_busy", 64'(busy), 1);
        end
        @(negedge clk);
        checkOutput("tmo_pulse", 64'(tmoErr), 1);
        checkOutput("tmo_rsp_valid", 64'(rspValid), 64'(oneHot(k)));
        checkOutput("tmo_rsp_data_zero", 64'(rspData), 0);
        @(negedge clk);
        checkOutput("tmo_pulse_end", 64'(tmoErr), 0);
        checkOutput("tmo_idle", 64'(busy), 0);
        modelPtr = (k + 1) % N_CH;

        // Matching reply on the final count cycle beats the timeout
        chData[2] = 32'h2222_0002;
        pending   = 4'b0100;
        grantPhase(0, k);
        repeat (TIMEOUT - 1) @(negedge clk);
        v        = 32'h600d_0002;
        impValid = 1'b1;
        impId    = ID_W'(k);
        impData  = v;
        @(negedge clk);
        impValid = 1'b0;
        checkOutput("late_reply_rsp_valid", 64'(rspValid), 64'(oneHot(k)));
        checkOutput("late_reply_rsp_data", 64'(rspData), 64'(v));
        checkOutput("late_reply_no_tmo", 64'(tmoErr), 0);
        @(negedge clk);
        checkOutput("late_reply_idle", 64'(busy), 0);
        modelPtr = (k + 1) % N_CH;
`else
        // Without the watchdog the arbiter keeps waiting for the reply
        chData[1] = 32'h1111_0001;
        pending   = 4'b0010;
        grantPhase(0, k);
        sawTmo = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tmoErr !== 1'b0) sawTmo = 1'b1;
        end
        checkOutput("no_tmo_pulse", 64'(sawTmo), 0);
        checkOutput("still_waiting", 64'(busy), 1);
        checkOutput("still_no_rsp", 64'(rspValid), 0);
        rstN = 1'b0;
        @(negedge clk);
        rstN     = 1'b1;
        modelPtr = 0;
        @(negedge clk);
`endif

        // Randomized traffic: requests accumulate and stay held until granted
        for (int t = 0; t < 40; t++) begin
            newBits = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            if ((pending | newBits) == '0) newBits = oneHot(int'($urandom_range(0, N_CH - 1)));
            for (int c = 0; c < N_CH; c++) begin
                if (newBits[c] && !pending[c]) chData[c] = $urandom;
            end
            pending = pending | newBits;
            grantPhase(int'($urandom_range(0, 3)), k);
            replyPhase(k, int'($urandom_range(0, 1)), -1, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cosim_link_arbiter.md
Name: cosim_link_arbiter

Overview:
- Shares the single co-simulation export/import link to the Python-side host among N HDL requesters.
- Each transaction runs in order: a requester word is exported with its channel id, the matching imported reply is awaited, and the reply is routed back to that requester.
- Sits between per-channel cosim adapters and the DPI bridge shim (the xsimintf_export/xsimintf_import wrapper).
- Only one transaction is outstanding at a time; channels are selected round-robin.

Parameters:
- N_CH, 4, number of requesters (2..16).
- DATA_W, 32, width of exported and imported data words.
- ID_W, 4, channel id width; must satisfy 2**ID_W >= N_CH.
- TIMEOUT, 1024, cycles to wait in WAIT_IMP before aborting (used only with COSIM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_CH  per-channel request; held high until the matching gnt bit pulses.
- req_data  in  N_CH*DATA_W  per-channel export word; channel i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  N_CH  one-hot, one-cycle pulse; req_data of that channel is captured in the same cycle.
- rsp_valid  out  N_CH  one-hot, one-cycle pulse delivering the reply.
- rsp_data  out  DATA_W  reply word; valid while any rsp_valid bit is high.
- exp_valid  out  1  export word is available to the link.
- exp_ready  in  1  link accepts the export word.
- exp_data  out  DATA_W  word being exported.
- exp_id  out  ID_W  channel id of the exported word.
- imp_valid  in  1  imported reply is present (single cycle).
- imp_data  in  DATA_W  reply word.
- imp_id  in  ID_W  channel id the reply belongs to.
- busy  out  1  high whenever the FSM is not in IDLE.
- id_err  out  1  one-cycle pulse when imp_valid arrives with a mismatched imp_id.
- timeout_err  out  1  one-cycle pulse on timeout abort (tied 0 when the macro is absent).

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; round-robin pointer = 0.
  - All outputs 0, including exp_data, exp_id and rsp_data.
- FSM states: IDLE, EXPORT, WAIT_IMP, RESPOND.
- IDLE:
  - If req != 0, pick the first set bit at or after the pointer, wrapping from N_CH-1 to 0.
  - Next cycle: gnt[k]=1 for exactly one cycle, exp_data=req_data[k], exp_id=k, exp_valid=1; state=EXPORT.
- EXPORT:
  - exp_valid is held, with exp_data and exp_id stable, until exp_ready=1.
  - On the handshake cycle: exp_valid drops next cycle; state=WAIT_IMP.
- WAIT_IMP:
  - imp_valid with imp_id==k: latch imp_data; state=RESPOND.
  - imp_valid with imp_id!=k: pulse id_err for one cycle; discard the data; stay in WAIT_IMP.
  - imp_valid in any other state is ignored and does not pulse id_err.
- RESPOND:
  - rsp_valid[k]=1 and rsp_data=latched reply, for one cycle.
  - Pointer := (k+1) mod N_CH; state=IDLE.
  - rsp_data holds its value after the pulse.
- Minimum latency is 4 cycles from req sampled to rsp_valid, when exp_ready is already high and imp_valid arrives the cycle after the export handshake.
- The arbiter accepts no new request until it returns to IDLE. The IDLE->grant decision takes one cycle, so back-to-back transactions are spaced at least 4 cycles apart.
- Fairness: with all requests held, channels are granted 0,1,2,…,N_CH-1,0,…
- A req deasserted before its grant is dropped without side effects; a requester must not deassert after asserting.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; no rsp_valid is issued for the aborted channel.
  - The pointer returns to 0.
- id_err and timeout_err are pulses, not sticky.
- exp_id is zero-extended when ID_W exceeds the width needed for N_CH.

Optional Feature:
- Macro: COSIM_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_IMP and increments each cycle spent there.
  - When it reaches TIMEOUT-1 without a matching reply: timeout_err pulses, rsp_valid[k] pulses with rsp_data=0, the pointer advances, and the FSM returns to IDLE.
  - A matching imp_valid on the final count cycle wins; no timeout is raised.
- When undefined:
  - No counter is synthesised; timeout_err is constant 0.
  - WAIT_IMP waits indefinitely for the matching reply.

Test Plan:
- Single request: req=4'b0010, req_data[1]=32'hfafafafa, exp_ready=1, imp_valid with imp_id=1 and imp_data=32'h0000_0001 one cycle after the export handshake -> gnt=4'b0010 one cycle after req, exp_data=32'hfafafafa with exp_id=1, rsp_valid=4'b0010 with rsp_data=1, 4 cycles from req to rsp_valid.
- Round-robin: req=4'b1111 held, each channel replying with its own id -> grant order 0,1,2,3,0; exactly one gnt bit per transaction.
- Backpressure: exp_ready low for 5 cycles after exp_valid -> exp_valid, exp_data and exp_id stable throughout; handshake on the 6th cycle; no second gnt meanwhile.
- Wrong id: active channel 2 receives imp_id=3 -> id_err pulses once, busy stays 1; a later reply with imp_id=2 completes with rsp_valid=4'b0100.
- Mid-transaction reset: rst_n driven low during WAIT_IMP -> all outputs 0 within the same cycle; after release, req=4'b1000 is granted to channel 3 and a new transaction completes normally.
- Timeout (COSIM_ARB_TIMEOUT_EN, TIMEOUT=8, no reply) -> timeout_err pulses 8 cycles after entering WAIT_IMP, together with the rsp_valid pulse and rsp_data=0; without the macro the FSM stays in WAIT_IMP for 100 cycles and timeout_err remains 0.
